// File: rtl/batch_norm_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | batch_norm_stream_pkg                                                    |
// | Shared defaults and helpers for the streaming batch-norm block.          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package batch_norm_stream_pkg;

    localparam int BN_DATA_W    = 16;
    localparam int BN_FRAC_W    = 8;
    localparam int BN_NUM_CH    = 16;
    localparam int BN_SCALE_ONE = 1 << BN_FRAC_W;
    localparam int BN_SAT_MAX   = (1 << (BN_DATA_W - 1)) - 1;
    localparam int BN_SAT_MIN   = -(1 << (BN_DATA_W - 1));

    // Index compared at 32 bits so a table that fills its index space does not
    // collapse into a constant comparison.
    function automatic logic ch_in_range(input int unsigned idx, input int unsigned num_ch);
        return idx < num_ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bn_param_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bn_param_table                                                           |
// | Per-channel mean/scale/bias registers, 1 write port, 1 registered read.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module bn_param_table
    import batch_norm_stream_pkg::*;
#(
    parameter int DATA_W = BN_DATA_W,
    parameter int FRAC_W = BN_FRAC_W,
    parameter int NUM_CH = BN_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [CH_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0] i_wmean,
    input  logic [DATA_W-1:0] i_wscale,
    input  logic [DATA_W-1:0] i_wbias,
    input  logic              i_re,
    input  logic [CH_W-1:0]   i_raddr,
    output logic [DATA_W-1:0] o_mean,
    output logic [DATA_W-1:0] o_scale,
    output logic [DATA_W-1:0] o_bias
);

    localparam logic [DATA_W-1:0] c_SCALE_ONE = DATA_W'(1 << FRAC_W);

    logic [DATA_W-1:0] r_mean  [NUM_CH];
    logic [DATA_W-1:0] r_scale [NUM_CH];
    logic [DATA_W-1:0] r_bias  [NUM_CH];
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign w_wr_ok = ch_in_range(32'(i_waddr), 32'(NUM_CH));
    assign w_rd_ok = ch_in_range(32'(i_raddr), 32'(NUM_CH));

    // Read and write share one edge, so a same-channel read sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_mean[i]  <= '0;
                r_scale[i] <= c_SCALE_ONE;
                r_bias[i]  <= '0;
            end
            o_mean  <= '0;
            o_scale <= c_SCALE_ONE;
            o_bias  <= '0;
        end else begin
            if (i_we && w_wr_ok) begin
                r_mean[i_waddr]  <= i_wmean;
                r_scale[i_waddr] <= i_wscale;
                r_bias[i_waddr]  <= i_wbias;
            end
            if (i_re) begin
                if (w_rd_ok) begin
                    o_mean  <= r_mean[i_raddr];
                    o_scale <= r_scale[i_raddr];
                    o_bias  <= r_bias[i_raddr];
                end else begin
                    o_mean  <= '0;
                    o_scale <= c_SCALE_ONE;
                    o_bias  <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/batch_norm_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | batch_norm_stream                                                        |
// | 3-stage streaming y = sat((x - mean[c]) * scale[c] + bias[c]).           |
// | Option macro BN_FUSED_RELU_EN: clamp negative results to zero.           |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module batch_norm_stream
    import batch_norm_stream_pkg::*;
#(
    parameter int DATA_W = BN_DATA_W,
    parameter int FRAC_W = BN_FRAC_W,
    parameter int NUM_CH = BN_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CH_W-1:0]   s_ch,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CH_W-1:0]   m_ch,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_addr,
    input  logic [DATA_W-1:0] cfg_mean,
    input  logic [DATA_W-1:0] cfg_scale,
    input  logic [DATA_W-1:0] cfg_bias,
    output logic [15:0]       sat_cnt
);

    localparam int c_PROD_W = 2 * DATA_W + 1;
    localparam logic signed [c_PROD_W-1:0] c_HALF    = c_PROD_W'(2 ** (FRAC_W - 1));
    localparam logic signed [c_PROD_W-1:0] c_SAT_MAX = c_PROD_W'($signed({1'b0, {(DATA_W-1){1'b1}}}));
    localparam logic signed [c_PROD_W-1:0] c_SAT_MIN = c_PROD_W'($signed({1'b1, {(DATA_W-1){1'b0}}}));

    logic                       w_en;
    logic [DATA_W-1:0]          w_mean, w_scale, w_bias;
    logic                       r_s1_valid;
    logic [DATA_W-1:0]          r_s1_x;
    logic [CH_W-1:0]            r_s1_ch;
    logic signed [DATA_W:0]     w_diff;
    logic signed [c_PROD_W-1:0] w_prod;
    logic                       r_s2_valid;
    logic signed [c_PROD_W-1:0] r_s2_prod;
    logic [DATA_W-1:0]          r_s2_bias;
    logic [CH_W-1:0]            r_s2_ch;
    logic signed [c_PROD_W-1:0] w_sum;
    logic                       w_clip_hi, w_clip_lo;
    logic [DATA_W-1:0]          w_sat_data;
    logic [DATA_W-1:0]          w_out;

    // Whole pipe advances together; any stall at the output freezes every stage.
    assign w_en    = !m_valid || m_ready;
    assign s_ready = w_en && !rst;

    bn_param_table #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .i_we     (cfg_we),
        .i_waddr  (cfg_addr),
        .i_wmean  (cfg_mean),
        .i_wscale (cfg_scale),
        .i_wbias  (cfg_bias),
        .i_re     (w_en),
        .i_raddr  (s_ch),
        .o_mean   (w_mean),
        .o_scale  (w_scale),
        .o_bias   (w_bias)
    );

    assign w_diff = $signed({r_s1_x[DATA_W-1], r_s1_x}) - $signed({w_mean[DATA_W-1], w_mean});
    assign w_prod = c_PROD_W'(w_diff) * c_PROD_W'($signed(w_scale));
    assign w_sum  = ((r_s2_prod + c_HALF) >>> FRAC_W) + c_PROD_W'($signed(r_s2_bias));

    always_comb begin
        w_clip_hi  = w_sum > c_SAT_MAX;
        w_clip_lo  = w_sum < c_SAT_MIN;
        w_sat_data = w_sum[DATA_W-1:0];
        if (w_clip_hi) begin
            w_sat_data = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_clip_lo) begin
            w_sat_data = {1'b1, {(DATA_W-1){1'b0}}};
        end
`ifdef BN_FUSED_RELU_EN
        w_out = w_sat_data[DATA_W-1] ? '0 : w_sat_data;
`else
        w_out = w_sat_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_ch    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_bias  <= '0;
            r_s2_ch    <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_ch       <= '0;
            sat_cnt    <= '0;
        end else if (w_en) begin
            r_s1_valid <= s_valid;
            r_s1_x     <= s_data;
            r_s1_ch    <= s_ch;
            r_s2_valid <= r_s1_valid;
            r_s2_prod  <= w_prod;
            r_s2_bias  <= w_bias;
            r_s2_ch    <= r_s1_ch;
            m_valid    <= r_s2_valid;
            m_data     <= w_out;
            m_ch       <= r_s2_ch;
            if (r_s2_valid && (w_clip_hi || w_clip_lo) && (sat_cnt != 16'hFFFF)) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_batch_norm_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_batch_norm_stream                                                     |
// | Directed + randomized bench with an arithmetic reference model.          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_batch_norm_stream;
    import batch_norm_stream_pkg::*;

    localparam int NCH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = '0;
    logic [3:0]  s_ch = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] m_data;
    logic [3:0]  m_ch;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [15:0] cfg_mean = '0, cfg_scale = '0, cfg_bias = '0;
    logic [15:0] sat_cnt;

    always #5 clk = ~clk;

    batch_norm_stream dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_ch(s_ch), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_ch(m_ch), .m_valid(m_valid), .m_ready(m_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mean(cfg_mean),
        .cfg_scale(cfg_scale), .cfg_bias(cfg_bias), .sat_cnt(sat_cnt)
    );

    typedef struct {
        logic [15:0] d;
        logic [3:0]  ch;
        bit          sat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          mdl_mean[NCH], mdl_scale[NCH], mdl_bias[NCH];
    int          exp_sat = 0;
    int          rx_cnt = 0;
    logic [15:0] last_data = '0;
    bit          saw_backpressure = 1'b0;
    bit          rand_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic void model_identity();
        for (int i = 0; i < NCH; i++) begin
            mdl_mean[i]  = 0;
            mdl_scale[i] = BN_SCALE_ONE;
            mdl_bias[i]  = 0;
        end
    endfunction

    // y = clamp(round_half_up((x - mean) * scale / 2^FRAC) + bias)
    function automatic int ref_out(input int x, input int ch, output bit sat);
        longint prod, r, sum;
        prod = longint'(x - mdl_mean[ch]) * longint'(mdl_scale[ch]);
        r    = (prod + longint'(BN_SCALE_ONE / 2)) >>> BN_FRAC_W;
        sum  = r + longint'(mdl_bias[ch]);
        sat  = 1'b0;
        if (sum > longint'(BN_SAT_MAX)) begin
            sum = BN_SAT_MAX; sat = 1'b1;
        end else if (sum < longint'(BN_SAT_MIN)) begin
            sum = BN_SAT_MIN; sat = 1'b1;
        end
`ifdef BN_FUSED_RELU_EN
        if (sum < 0) sum = 0;
`endif
        return int'(sum);
    endfunction

    // Output scoreboard: every transferred beat must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && s_valid && !s_ready) saw_backpressure = 1'b1;
        if (m_valid && m_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_beat observed=0x%0h expected=none", m_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(m_data), 32'(e.d));
                chk("beat_ch", 32'(m_ch), 32'(e.ch));
                if (e.sat && exp_sat < 65535) exp_sat++;
            end
            rx_cnt++;
            last_data = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int ch);
        exp_t e;
        bit   sat;
        int   waited;
        waited  = 0;
        s_data  = 16'(x);
        s_ch    = 4'(ch);
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready) begin
            waited++;
            if (waited > 100) begin
                chk("send_timeout", 32'(waited), 32'd0);
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        e.d   = 16'(ref_out(x, ch, sat));
        e.ch  = 4'(ch);
        e.sat = sat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int mean, input int scale, input int bias);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(ch);
        cfg_mean  = 16'(mean);
        cfg_scale = 16'(scale);
        cfg_bias  = 16'(bias);
        @(posedge clk);
        mdl_mean[ch]  = s16(16'(mean));
        mdl_scale[ch] = s16(16'(scale));
        mdl_bias[ch]  = s16(16'(bias));
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   sat;
        int   rx_before;
        model_identity();

        // Reset state
        tick(); tick();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_ch", 32'(m_ch), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        tick();

        // Identity pass-through and 3-cycle latency
        send(32'h0123, 0);
        chk("lat_c1", 32'(m_valid), 32'd0);
        tick();
        chk("lat_c2", 32'(m_valid), 32'd0);
        tick();
        chk("lat_c3", 32'(m_valid), 32'd1);
        chk("ident_data", 32'(m_data), 32'h0123);
        drain();

        // Programmed channel
        cfg_write(2, 16'h0064, 16'h0200, 16'hFFF6);
        send(150, 2);
        drain();
        chk("ch2_data", 32'(last_data), 32'h005A);

        // Saturation both ways
        cfg_write(3, 0, 16'h7FFF, 0);
        send(16'h4000, 3);
        drain();
        chk("sat_hi_data", 32'(last_data), 32'h7FFF);
        chk("sat_hi_cnt", 32'(sat_cnt), 32'd1);
        send(s16(16'hC000), 3);
        drain();
`ifdef BN_FUSED_RELU_EN
        chk("sat_lo_data", 32'(last_data), 32'h0000);
`else
        chk("sat_lo_data", 32'(last_data), 32'h8000);
`endif
        chk("sat_lo_cnt", 32'(sat_cnt), 32'd2);

        // Round half up with scale 0.5
        cfg_write(4, 0, 16'h0080, 0);
        send(3, 4);  drain(); chk("rnd_p3", 32'(last_data), 32'h0002);
        send(-3, 4); drain();
`ifdef BN_FUSED_RELU_EN
        chk("rnd_m3", 32'(last_data), 32'h0000);
`else
        chk("rnd_m3", 32'(last_data), 32'hFFFF);
`endif
        send(1, 4);  drain(); chk("rnd_p1", 32'(last_data), 32'h0001);

        // 8-beat burst with output stalled on cycles 2..6
        rx_before = rx_cnt;
        saw_backpressure = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send(s16(16'($urandom)), i % 5);
            begin
                for (int k = 0; k < 12; k++) begin
                    m_ready = !(k >= 2 && k <= 6);
                    tick();
                end
                m_ready = 1'b1;
            end
        join
        drain();
        chk("burst_backpressure", 32'(saw_backpressure), 32'd1);
        chk("burst_count", 32'(rx_cnt - rx_before), 32'd8);

        // Reset while beats are in flight
        send(10, 0); send(20, 0); send(30, 0);
        rst = 1'b1;
        tick();
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        exp_q.delete();
        model_identity();
        exp_sat = 0;
        rst = 1'b0;
        rx_before = rx_cnt;
        for (int k = 0; k < 10; k++) tick();
        chk("midrst_no_stale", 32'(rx_cnt - rx_before), 32'd0);
        chk("midrst_sat_cnt", 32'(sat_cnt), 32'd0);

        // Negative bias on channel 0
        cfg_write(0, 0, BN_SCALE_ONE, 16'hFFF6);
        send(0, 0);
        drain();
`ifdef BN_FUSED_RELU_EN
        chk("bias_neg_data", 32'(last_data), 32'h0000);
`else
        chk("bias_neg_data", 32'(last_data), 32'hFFF6);
`endif
        chk("bias_neg_sat", 32'(sat_cnt), 32'd0);

        // Same-cycle write and read of channel 1: beat sees the old entry
        cfg_write(1, 0, 16'h0200, 5);
        cfg_we = 1'b1; cfg_addr = 4'd1;
        cfg_mean = 16'd0; cfg_scale = 16'h0100; cfg_bias = 16'd100;
        s_data = 16'd10; s_ch = 4'd1; s_valid = 1'b1;
        @(negedge clk);
        chk("rbw_ready", 32'(s_ready), 32'd1);
        e.d = 16'(ref_out(10, 1, sat)); e.ch = 4'd1; e.sat = sat;
        exp_q.push_back(e);
        @(posedge clk);
        mdl_mean[1] = 0; mdl_scale[1] = 16'h0100; mdl_bias[1] = 100;
        #1;
        cfg_we = 1'b0; s_valid = 1'b0;
        drain();
        chk("rbw_old", 32'(last_data), 32'h0019);
        send(10, 1);
        drain();
        chk("rbw_new", 32'(last_data), 32'h006E);

        // Randomized traffic with random back-pressure and interleaved config
        fork
            begin
                while (!rand_done) begin
                    m_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                cfg_write($urandom_range(0, NCH - 1),
                          s16(16'($urandom)),
                          ($urandom_range(0, 3) == 0) ? s16(16'($urandom))
                                                      : int'($urandom_range(0, 1023)) - 512,
                          s16(16'($urandom)));
            end else begin
                send(s16(16'($urandom)), $urandom_range(0, NCH - 1));
            end
        end
        rand_done = 1'b1;
        tick(); tick();
        drain();
        chk("final_sat_cnt", 32'(sat_cnt), 32'(exp_sat));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
